mc_control: RTL and testbench

- Multicycle sequencer for the MIPS datapath (ifu, RegFile, ALU, DataMemory, ext, muxes).
- Replaces the purely combinational Control decoder with an FSM that spreads each instruction over fetch, decode, execute, memory and writeback states.
- Throttles on a memory-ready handshake and counts retired instructions.
- Sits between the instruction register and all datapath write enables and mux selects.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_decode.sv | 31 +++
 rtl/mc_control.sv | 195 +++++++++++++++++++
 tb/tb_mc_control.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes,
// instruction classes and datapath mux/ALU select values.
package mc_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMemRd  = 3'd3,
    StMemWr  = 3'd4,
    StWb     = 3'd5,
    StBranch = 3'd6,
    StJump   = 3'd7
  } mc_state_e;

  typedef enum logic [3:0] {
    IcRtypeAdd,
    IcRtypeSub,
    IcOri,
    IcLui,
    IcLw,
    IcSw,
    IcBeq,
    IcJ,
    IcJal,
    IcIllegal
  } mc_iclass_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluOr   = 3'b010;
  localparam logic [2:0] AluLui  = 3'b011;

  localparam logic [1:0] NpcPlus4  = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;

  localparam logic [1:0] DstRt  = 2'b00;
  localparam logic [1:0] DstRd  = 2'b01;
  localparam logic [1:0] DstR31 = 2'b10;

  localparam logic [1:0] WbAlu  = 2'b00;
  localparam logic [1:0] WbMem  = 2'b01;
  localparam logic [1:0] WbLink = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct to instruction-class decoder.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output mc_iclass_e iclass_o
);

  always_comb begin
    iclass_o = IcIllegal;
    unique case (op_i)
      OpRtype: begin
        unique case (funct_i)
          FnAddu:  iclass_o = IcRtypeAdd;
          FnSubu:  iclass_o = IcRtypeSub;
          default: iclass_o = IcIllegal;
        endcase
      end
      OpOri:   iclass_o = IcOri;
      OpLui:   iclass_o = IcLui;
      OpLw:    iclass_o = IcLw;
      OpSw:    iclass_o = IcSw;
      OpBeq:   iclass_o = IcBeq;
      OpJ:     iclass_o = IcJ;
      OpJal:   iclass_o = IcJal;
      default: iclass_o = IcIllegal;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback, throttles on
// mem_ready with a timeout abort, and counts retired instructions.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             IRWr_o,
  output logic             PCWr_o,
  output logic [1:0]       nPC_sel_o,
  output logic             RegWr_o,
  output logic [1:0]       RegDst_o,
  output logic [1:0]       MemtoReg_o,
  output logic             ALUSrc_o,
  output logic             ExtOp_o,
  output logic [2:0]       ALUctr_o,
  output logic             MemWr_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  mc_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             timeout;
  mc_iclass_e       iclass;

  mc_decode u_decode (
    .op_i     (op_i),
    .funct_i  (funct_i),
    .iclass_o (iclass)
  );

  assign timeout = (wait_q == WaitW'(TIMEOUT - 1)) && !mem_ready_i;

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    retire     = 1'b0;
    mem_req_o  = 1'b0;
    IRWr_o     = 1'b0;
    PCWr_o     = 1'b0;
    nPC_sel_o  = NpcPlus4;
    RegWr_o    = 1'b0;
    RegDst_o   = DstRt;
    MemtoReg_o = WbAlu;
    ALUSrc_o   = 1'b0;
    ExtOp_o    = 1'b0;
    ALUctr_o   = AluAdd;
    MemWr_o    = 1'b0;
    illegal_o  = 1'b0;
    bus_err_o  = 1'b0;

    // ALU controls set in EXEC stay asserted through the memory and writeback states.
    if (state_q inside {StExec, StMemRd, StMemWr, StWb}) begin
      unique case (iclass)
        IcRtypeAdd: ALUctr_o = AluAdd;
        IcRtypeSub: ALUctr_o = AluSub;
        IcOri: begin
          ALUSrc_o = 1'b1;
          ALUctr_o = AluOr;
        end
        IcLui: begin
          ALUSrc_o = 1'b1;
          ALUctr_o = AluLui;
        end
        IcLw, IcSw: begin
          ALUSrc_o = 1'b1;
          ExtOp_o  = 1'b1;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      StFetch: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          IRWr_o  = 1'b1;
          PCWr_o  = 1'b1;
          state_d = StDecode;
        end else if (timeout) begin
          bus_err_o = 1'b1;
          state_d   = StFetch;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        unique case (iclass)
          IcJ, IcJal: state_d = StJump;
          IcBeq:      state_d = StBranch;
          IcIllegal: begin
            illegal_o = 1'b1;
            state_d   = StFetch;
          end
          default:    state_d = StExec;
        endcase
      end
      StExec: begin
        unique case (iclass)
          IcLw:    state_d = StMemRd;
          IcSw:    state_d = StMemWr;
          default: state_d = StWb;
        endcase
      end
      StMemRd, StMemWr: begin
        mem_req_o = 1'b1;
        MemWr_o   = (state_q == StMemWr);
        if (mem_ready_i) begin
          state_d = (state_q == StMemWr) ? StFetch : StWb;
          retire  = (state_q == StMemWr);
        end else if (timeout) begin
          bus_err_o = 1'b1;
          state_d   = StFetch;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        RegWr_o = 1'b1;
        if (iclass inside {IcRtypeAdd, IcRtypeSub}) RegDst_o = DstRd;
        if (iclass == IcLw) MemtoReg_o = WbMem;
        state_d = StFetch;
        retire  = 1'b1;
      end
      StBranch: begin
        ALUctr_o  = AluSub;
        ExtOp_o   = 1'b1;
        nPC_sel_o = NpcBranch;
        PCWr_o    = zero_i;
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StJump: begin
        PCWr_o    = 1'b1;
        nPC_sel_o = NpcJump;
        if (iclass == IcJal) begin
          RegWr_o    = 1'b1;
          RegDst_o   = DstR31;
          MemtoReg_o = WbLink;
        end
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    // Reset must silence every strobe immediately, not one edge later.
    if (!reset_ni) begin
      mem_req_o  = 1'b0;
      IRWr_o     = 1'b0;
      PCWr_o     = 1'b0;
      nPC_sel_o  = NpcPlus4;
      RegWr_o    = 1'b0;
      RegDst_o   = DstRt;
      MemtoReg_o = WbAlu;
      ALUSrc_o   = 1'b0;
      ExtOp_o    = 1'b0;
      ALUctr_o   = AluAdd;
      MemWr_o    = 1'b0;
      illegal_o  = 1'b0;
      bus_err_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks addu, lw with stalls, beq taken/not, jal,
// an illegal op, fetch timeout, ready-at-limit and reset during a store.
module tb_mc_control;

  logic        clk;
  logic        reset_n;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, ir_wr, pc_wr, reg_wr, alu_src, ext_op, mem_wr, illegal, bus_err;
  logic [1:0]  npc_sel, reg_dst, mem_to_reg;
  logic [2:0]  alu_ctr, state;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  mc_control #(
    .TIMEOUT (16),
    .CNT_W   (32)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .op_i        (op),
    .funct_i     (funct),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .mem_req_o   (mem_req),
    .IRWr_o      (ir_wr),
    .PCWr_o      (pc_wr),
    .nPC_sel_o   (npc_sel),
    .RegWr_o     (reg_wr),
    .RegDst_o    (reg_dst),
    .MemtoReg_o  (mem_to_reg),
    .ALUSrc_o    (alu_src),
    .ExtOp_o     (ext_op),
    .ALUctr_o    (alu_ctr),
    .MemWr_o     (mem_wr),
    .state_o     (state),
    .illegal_o   (illegal),
    .bus_err_o   (bus_err),
    .retired_o   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    op        = 6'b000000;
    funct     = 6'b100001;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #12;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_irwr", 32'(ir_wr), 32'd0);
    check_eq("rst_pcwr", 32'(pc_wr), 32'd0);
    check_eq("rst_retired", retired, 32'd0);

    // addu: 0 -> 1 -> 2 -> 5 -> 0
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("add_fetch_state", 32'(state), 32'd0);
    check_eq("add_fetch_req", 32'(mem_req), 32'd1);
    check_eq("add_fetch_irwr", 32'(ir_wr), 32'd1);
    check_eq("add_fetch_pcwr", 32'(pc_wr), 32'd1);
    step();
    check_eq("add_decode_state", 32'(state), 32'd1);
    step();
    check_eq("add_exec_state", 32'(state), 32'd2);
    check_eq("add_exec_alusrc", 32'(alu_src), 32'd0);
    step();
    check_eq("add_wb_state", 32'(state), 32'd5);
    check_eq("add_wb_regwr", 32'(reg_wr), 32'd1);
    check_eq("add_wb_regdst", 32'(reg_dst), 32'd1);
    check_eq("add_wb_aluctr", 32'(alu_ctr), 32'd0);
    step();
    check_eq("add_back_fetch", 32'(state), 32'd0);
    check_eq("add_retired", retired, 32'd1);

    // lw with three stall cycles in MEMRD
    op = 6'b100011;
    step();
    check_eq("lw_decode", 32'(state), 32'd1);
    step();
    check_eq("lw_exec_state", 32'(state), 32'd2);
    check_eq("lw_exec_alusrc", 32'(alu_src), 32'd1);
    check_eq("lw_exec_extop", 32'(ext_op), 32'd1);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("lw_memrd_state", 32'(state), 32'd3);
      check_eq("lw_memrd_req", 32'(mem_req), 32'd1);
      check_eq("lw_memrd_buserr", 32'(bus_err), 32'd0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("lw_memrd_last", 32'(state), 32'd3);
    step();
    check_eq("lw_wb_state", 32'(state), 32'd5);
    check_eq("lw_wb_memtoreg", 32'(mem_to_reg), 32'd1);
    check_eq("lw_wb_regdst", 32'(reg_dst), 32'd0);
    step();
    check_eq("lw_retired", retired, 32'd2);

    // beq taken then not taken
    op   = 6'b000100;
    zero = 1'b1;
    step();
    step();
    check_eq("beq1_state", 32'(state), 32'd6);
    check_eq("beq1_pcwr", 32'(pc_wr), 32'd1);
    check_eq("beq1_npc", 32'(npc_sel), 32'd1);
    check_eq("beq1_aluctr", 32'(alu_ctr), 32'd1);
    step();
    zero = 1'b0;
    step();
    step();
    check_eq("beq0_state", 32'(state), 32'd6);
    check_eq("beq0_pcwr", 32'(pc_wr), 32'd0);
    step();
    check_eq("beq_retired", retired, 32'd4);

    // jal
    op = 6'b000011;
    step();
    step();
    check_eq("jal_state", 32'(state), 32'd7);
    check_eq("jal_pcwr", 32'(pc_wr), 32'd1);
    check_eq("jal_npc", 32'(npc_sel), 32'd2);
    check_eq("jal_regwr", 32'(reg_wr), 32'd1);
    check_eq("jal_regdst", 32'(reg_dst), 32'd2);
    check_eq("jal_memtoreg", 32'(mem_to_reg), 32'd2);
    step();
    check_eq("jal_next", 32'(state), 32'd0);
    check_eq("jal_retired", retired, 32'd5);

    // illegal opcode
    op = 6'b111111;
    step();
    check_eq("ill_pulse", 32'(illegal), 32'd1);
    step();
    check_eq("ill_next", 32'(state), 32'd0);
    check_eq("ill_clear", 32'(illegal), 32'd0);
    check_eq("ill_retired", retired, 32'd5);

    // fetch timeout: bus_err on the 16th cycle without ready
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      check_eq("to_wait_buserr", 32'(bus_err), 32'd0);
      step();
    end
    check_eq("to_buserr", 32'(bus_err), 32'd1);
    check_eq("to_pcwr", 32'(pc_wr), 32'd0);
    check_eq("to_irwr", 32'(ir_wr), 32'd0);
    step();
    check_eq("to_state", 32'(state), 32'd0);
    check_eq("to_buserr_clear", 32'(bus_err), 32'd0);

    // ready arriving exactly at the limit wins over the timeout
    for (int i = 0; i < 15; i++) step();
    mem_ready = 1'b1;
    op        = 6'b101011;
    #1;
    check_eq("lim_buserr", 32'(bus_err), 32'd0);
    check_eq("lim_irwr", 32'(ir_wr), 32'd1);

    // sw stalled in MEMWR, then async reset
    step();
    step();
    mem_ready = 1'b0;
    step();
    check_eq("sw_memwr_state", 32'(state), 32'd4);
    check_eq("sw_memwr_wr", 32'(mem_wr), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_memwr", 32'(mem_wr), 32'd0);
    check_eq("arst_req", 32'(mem_req), 32'd0);
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_retired", retired, 32'd0);
    step();
    reset_n = 1'b1;
    #1;
    check_eq("post_rst_state", 32'(state), 32'd0);
    check_eq("post_rst_memwr", 32'(mem_wr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
